tsv_repair_ctrl_2_7: RTL

Reconfiguration controller for the 2_7 CAC/local-FNS TSV link. It owns the 9-bit faulty-TSV flag vector `f_flag` that drives both `FNSadders_2_7` instances (sender and receiver), so both ends always switch to the same configuration. It accepts fault reports from the TSV test engine and stalls the coder data path while the flag vector changes and the FNS adders settle. It flags the link as unrepairable once the redundancy is exhausted.

---
 rtl/tsv_repair_pkg.sv | 18 +
 rtl/tsv_repair_timer.sv | 38 +++
 rtl/tsv_repair_ctrl_2_7.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/tsv_repair_pkg.sv
// Shared types and constants for the 2_7 TSV repair controller.
package tsv_repair_pkg;

  localparam int NTSV_2_7       = 9;
  localparam int MAX_FAULTS_2_7 = 7;
  localparam int IDXW           = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_UPDATE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_FAIL   = 3'd4
  } repair_state_t;

  typedef logic [NTSV_2_7-1:0] fflag_t;

endpackage

// File: rtl/tsv_repair_timer.sv
// 4-bit loadable down-counter shared by the drain and settle phases.
// expire is high while the count sits at 1, i.e. on the last stall cycle.
module tsv_repair_timer (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] value,
  output logic       expire
);

  logic [3:0] value_q;
  logic [3:0] value_d;

  // Load has priority over decrement.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (dec) begin
      value_d = value_q - 4'd1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign expire = (value_q == 4'd1);

endmodule

// File: rtl/tsv_repair_ctrl_2_7.sv
// Reconfiguration controller for the 2_7 CAC/local-FNS TSV link.
// Owns the faulty-TSV flag vector shared by both FNS adders and stalls the
// coder while that vector changes. Optional macro TSV_REPAIR_CLEAR_EN adds a
// clear_req input that wipes the flag vector through the same stall sequence.
module tsv_repair_ctrl_2_7
  import tsv_repair_pkg::*;
#(
  parameter int NTSV       = NTSV_2_7,
  parameter int MAX_FAULTS = MAX_FAULTS_2_7,
  parameter int DRAIN_CYC  = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic            clock,
  input  logic            rst_n,
`ifdef TSV_REPAIR_CLEAR_EN
  input  logic            clear_req,
`endif
  input  logic            fault_valid,
  input  logic [IDXW-1:0] fault_idx,
  output logic            fault_ready,
  output logic [NTSV-1:0] f_flag,
  output logic [3:0]      fault_cnt,
  output logic            data_en,
  output logic            busy,
  output logic            cfg_done,
  output logic            idx_err,
  output logic            fault_dup,
  output logic            link_fail
);

  repair_state_t   state_q, state_d;
  logic [NTSV-1:0] f_flag_q, f_flag_d;
  logic [3:0]      fault_cnt_q, fault_cnt_d;
  logic [IDXW-1:0] pend_idx_q, pend_idx_d;
  logic            pend_clr_q, pend_clr_d;
  logic            cfg_done_q, cfg_done_d;
  logic            idx_err_q, idx_err_d;
  logic            fault_dup_q, fault_dup_d;
  logic            link_fail_q, link_fail_d;

  logic            tmr_load, tmr_dec, tmr_expire;
  logic [3:0]      tmr_load_val, tmr_value;

  logic            clear_go, accept, idx_bad, is_dup, is_full;

`ifdef TSV_REPAIR_CLEAR_EN
  assign clear_go = (state_q == ST_IDLE) & clear_req;
`else
  assign clear_go = 1'b0;
`endif

  // A clear in the same cycle swallows the fault report.
  assign accept  = fault_valid & fault_ready & ~clear_go;
  assign idx_bad = (32'(fault_idx) >= NTSV);
  assign is_dup  = ~idx_bad & f_flag_q[fault_idx];
  assign is_full = (fault_cnt_q == 4'(MAX_FAULTS));

  tsv_repair_timer u_timer (
    .clock    (clock),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .expire   (tmr_expire)
  );

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_go) begin
          state_d = ST_DRAIN;
        end else if (accept && !idx_bad && !is_dup) begin
          state_d = is_full ? ST_FAIL : ST_DRAIN;
        end
      end
      ST_DRAIN:  if (tmr_expire) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_SETTLE;
      ST_SETTLE: if (tmr_expire) state_d = ST_IDLE;
      ST_FAIL:   state_d = ST_FAIL;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    fault_ready = (state_q == ST_IDLE);
    data_en     = (state_q == ST_IDLE);
    busy        = (state_q == ST_DRAIN) || (state_q == ST_UPDATE) ||
                  (state_q == ST_SETTLE);
  end

  // Datapath next values: flag vector, count, pending report, pulses, timer.
  always_comb begin
    f_flag_d     = f_flag_q;
    fault_cnt_d  = fault_cnt_q;
    pend_idx_d   = pend_idx_q;
    pend_clr_d   = pend_clr_q;
    cfg_done_d   = 1'b0;
    idx_err_d    = 1'b0;
    fault_dup_d  = 1'b0;
    link_fail_d  = link_fail_q;
    tmr_load     = 1'b0;
    tmr_load_val = 4'(DRAIN_CYC);
    tmr_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_go) begin
          pend_clr_d = 1'b1;
          tmr_load   = 1'b1;
        end else if (accept) begin
          if (idx_bad) begin
            idx_err_d = 1'b1;
          end else if (is_dup) begin
            fault_dup_d = 1'b1;
          end else if (is_full) begin
            link_fail_d = 1'b1;
          end else begin
            pend_idx_d = fault_idx;
            pend_clr_d = 1'b0;
            tmr_load   = 1'b1;
          end
        end
      end
      ST_DRAIN, ST_SETTLE: begin
        tmr_dec = (tmr_value != 4'd0);
        if (state_q == ST_SETTLE && tmr_expire) begin
          cfg_done_d = 1'b1;
        end
      end
      ST_UPDATE: begin
        if (pend_clr_q) begin
          f_flag_d    = '0;
          fault_cnt_d = 4'd0;
        end else begin
          f_flag_d    = f_flag_q | (NTSV'(1) << pend_idx_q);
          fault_cnt_d = fault_cnt_q + 4'd1;
        end
        tmr_load     = 1'b1;
        tmr_load_val = 4'(SETTLE_CYC);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      f_flag_q    <= '0;
      fault_cnt_q <= 4'd0;
      pend_idx_q  <= '0;
      pend_clr_q  <= 1'b0;
      cfg_done_q  <= 1'b0;
      idx_err_q   <= 1'b0;
      fault_dup_q <= 1'b0;
      link_fail_q <= 1'b0;
    end else begin
      f_flag_q    <= f_flag_d;
      fault_cnt_q <= fault_cnt_d;
      pend_idx_q  <= pend_idx_d;
      pend_clr_q  <= pend_clr_d;
      cfg_done_q  <= cfg_done_d;
      idx_err_q   <= idx_err_d;
      fault_dup_q <= fault_dup_d;
      link_fail_q <= link_fail_d;
    end
  end

  assign f_flag    = f_flag_q;
  assign fault_cnt = fault_cnt_q;
  assign cfg_done  = cfg_done_q;
  assign idx_err   = idx_err_q;
  assign fault_dup = fault_dup_q;
  assign link_fail = link_fail_q;

endmodule
